rx_bit_timer_ctrl: RTL and testbench

//  Sequences the serial receiver's bit timing with two internal up counters.
//  - Clock counter: 1..CLKS_PER_BIT, wraps to 1.
//  - Bit counter: 0..BITS_PER_BYTE-1.

---
 rtl/rx_bit_timer_if.sv | 28 ++
 rtl/rx_bit_timer_ctrl.sv | 105 ++++++++++
 tb/tb_rx_bit_timer_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_bit_timer_if.sv
// Handshake bundle between the edge/SOF detector (master) and the receive bit timer (slave).
// Widths follow the timer parameters, so instantiate it with the same values as the timer.
interface rx_bit_timer_if #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int BITS_PER_BYTE = 8
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;

    logic          start;
    logic          stop;
    logic          abort;
    logic          busy;
    logic          shift_strobe;
    logic          byte_done;
    logic [BW-1:0] bit_idx;
    logic [CW-1:0] clk_cnt;

    modport master (
        output start, stop, abort,
        input  busy, shift_strobe, byte_done, bit_idx, clk_cnt
    );

    modport slave (
        input  start, stop, abort,
        output busy, shift_strobe, byte_done, bit_idx, clk_cnt
    );
endinterface

// File: rtl/rx_bit_timer_ctrl.sv
// Serial receive bit timer: clock/bit counters with mid-bit shift strobe, end-of-byte
// pulse, resync on start, graceful drain on stop and immediate abort.
module rx_bit_timer_ctrl #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_POINT  = 4,
    parameter int BITS_PER_BYTE = 8
) (
    input  logic            clk,
    input  logic            n_rst,
    rx_bit_timer_if.slave   bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_POINT);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_BYTE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_p0, state_nxt;
    logic [CW-1:0] clk_cnt_p0, clk_cnt_nxt;
    logic [BW-1:0] bit_idx_p0, bit_idx_nxt;

    logic active;
    logic bit_end;
    logic byte_end;

    assign active   = (state_p0 != IDLE);
    assign bit_end  = (clk_cnt_p0 == CNT_LAST);
    assign byte_end = active && bit_end && (bit_idx_p0 == BIT_LAST);

    always_comb begin
        state_nxt   = state_p0;
        clk_cnt_nxt = clk_cnt_p0;
        bit_idx_nxt = bit_idx_p0;

        if (active) begin
            if (bit_end) begin
                clk_cnt_nxt = CNT_ONE;
                bit_idx_nxt = (bit_idx_p0 == BIT_LAST) ? '0 : bit_idx_p0 + BIT_ONE;
            end else begin
                clk_cnt_nxt = clk_cnt_p0 + CNT_ONE;
            end
        end

        // abort beats start beats stop; the stop-driven exits only land on the byte_done cycle
        if (bus.abort) begin
            state_nxt   = IDLE;
            clk_cnt_nxt = '0;
            bit_idx_nxt = '0;
        end else if (bus.start) begin
            state_nxt   = RUN;
            clk_cnt_nxt = CNT_ONE;
            bit_idx_nxt = '0;
        end else begin
            case (state_p0)
                RUN: begin
                    if (bus.stop) begin
                        if (byte_end) begin
                            state_nxt   = IDLE;
                            clk_cnt_nxt = '0;
                            bit_idx_nxt = '0;
                        end else begin
                            state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (byte_end) begin
                        state_nxt   = IDLE;
                        clk_cnt_nxt = '0;
                        bit_idx_nxt = '0;
                    end
                end
                default: state_nxt = state_p0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_p0   <= IDLE;
            clk_cnt_p0 <= '0;
            bit_idx_p0 <= '0;
        end else begin
            state_p0   <= state_nxt;
            clk_cnt_p0 <= clk_cnt_nxt;
            bit_idx_p0 <= bit_idx_nxt;
        end
    end

    // every output is a decode of the registered state, never of the inputs
    assign bus.busy         = active;
    assign bus.shift_strobe = active && (clk_cnt_p0 == CNT_SAMPLE);
    assign bus.byte_done    = byte_end;
    assign bus.bit_idx      = bit_idx_p0;
    assign bus.clk_cnt      = clk_cnt_p0;
endmodule

// File: tb/tb_rx_bit_timer_ctrl.sv
// Directed bench for rx_bit_timer_ctrl: default timing (8/4/8) plus a minimal 2/2/1 instance.
module tb_rx_bit_timer_ctrl;
    logic clk;
    logic n_rst;
    logic n_rst_s;

    int total = 0;
    int bad   = 0;

    rx_bit_timer_if #(.CLKS_PER_BIT(8), .BITS_PER_BYTE(8)) bus ();
    rx_bit_timer_if #(.CLKS_PER_BIT(2), .BITS_PER_BYTE(1)) bus_s ();

    rx_bit_timer_ctrl #(.CLKS_PER_BIT(8), .SAMPLE_POINT(4), .BITS_PER_BYTE(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    rx_bit_timer_ctrl #(.CLKS_PER_BIT(2), .SAMPLE_POINT(2), .BITS_PER_BYTE(1)) dut_s (
        .clk   (clk),
        .n_rst (n_rst_s),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic st;
        logic sp;
        logic ab;
        logic busy;
        logic strb;
        logic done;
        int   idx;
        int   cnt;
    } vec_t;

    vec_t tbl   [12];
    vec_t tbl_s [11];

    function automatic int pk(input logic b, input logic s, input logic d, input int idx, input int cnt);
        return (int'(b) << 18) | (int'(s) << 17) | (int'(d) << 16) | (idx << 8) | cnt;
    endfunction

    function automatic int act_m();
        return pk(bus.busy, bus.shift_strobe, bus.byte_done, int'(bus.bit_idx), int'(bus.clk_cnt));
    endfunction

    function automatic int act_s();
        return pk(bus_s.busy, bus_s.shift_strobe, bus_s.byte_done, int'(bus_s.bit_idx), int'(bus_s.clk_cnt));
    endfunction

    // n = edges since the start edge, with 8 clocks/bit, sample at 4, 8 bits/byte
    function automatic int run_exp(input int n);
        return pk(1'b1, (n % 8) == 3, (n % 64) == 63, (n / 8) % 8, (n % 8) + 1);
    endfunction

    function automatic vec_t mk(input logic st, sp, ab, b, s, d, input int idx, cnt);
        vec_t v;
        v.st = st; v.sp = sp; v.ab = ab;
        v.busy = b; v.strb = s; v.done = d; v.idx = idx; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic sp, input logic ab);
        bus.start = st; bus.stop = sp; bus.abort = ab;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic cyc_s(input logic st, input logic sp, input logic ab);
        bus_s.start = st; bus_s.stop = sp; bus_s.abort = ab;
        @(posedge clk);
        #1;
        bus_s.start = 1'b0; bus_s.stop = 1'b0; bus_s.abort = 1'b0;
    endtask

    initial begin
        int strobes;
        int dones;

        //              st    sp    ab    busy  strb  done  idx cnt
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        tbl_s[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl_s[1]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        tbl_s[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 2);
        tbl_s[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        tbl_s[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 2);
        tbl_s[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl_s[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        tbl_s[7]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 2);
        tbl_s[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl_s[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        tbl_s[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 2);

        n_rst = 1'b0;
        n_rst_s = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.abort = 1'b0;
        bus_s.start = 1'b0; bus_s.stop = 1'b0; bus_s.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_main", act_m(), pk(1'b0, 1'b0, 1'b0, 0, 0));
        chk("reset_small", act_s(), pk(1'b0, 1'b0, 1'b0, 0, 0));
        n_rst = 1'b1;
        n_rst_s = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].st, tbl[i].sp, tbl[i].ab);
            chk($sformatf("tbl_main[%0d]", i), act_m(),
                pk(tbl[i].busy, tbl[i].strb, tbl[i].done, tbl[i].idx, tbl[i].cnt));
        end

        // three back-to-back bytes from one start
        strobes = 0;
        dones = 0;
        cyc(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 192; n++) begin
            if (n > 0) cyc(1'b0, 1'b0, 1'b0);
            chk($sformatf("run[%0d]", n), act_m(), run_exp(n));
            strobes += int'(bus.shift_strobe);
            dones += int'(bus.byte_done);
        end
        chk("run_strobe_count", strobes, 24);
        chk("run_done_count", dones, 3);
        cyc(1'b0, 1'b0, 1'b1);
        chk("run_abort_idle", act_m(), pk(1'b0, 1'b0, 1'b0, 0, 0));

        // stop at bit 2 drains the byte; a second stop inside DRAIN is ignored
        cyc(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 16; n++) cyc(1'b0, 1'b0, 1'b0);
        chk("pre_stop", act_m(), run_exp(16));
        dones = 0;
        cyc(1'b0, 1'b1, 1'b0);
        for (int n = 17; n <= 63; n++) begin
            if (n > 17) cyc(1'b0, n == 30, 1'b0);
            chk($sformatf("drain[%0d]", n), act_m(), run_exp(n));
            dones += int'(bus.byte_done);
        end
        chk("drain_done_count", dones, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("drain_end_idle", act_m(), pk(1'b0, 1'b0, 1'b0, 0, 0));

        // stop sampled in the byte_done cycle goes straight to IDLE
        cyc(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 63; n++) cyc(1'b0, 1'b0, 1'b0);
        chk("stop_at_done_pre", act_m(), run_exp(63));
        cyc(1'b0, 1'b1, 1'b0);
        chk("stop_at_done_idle", act_m(), pk(1'b0, 1'b0, 1'b0, 0, 0));

        // abort at clk_cnt=5, bit_idx=3
        cyc(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 28; n++) cyc(1'b0, 1'b0, 1'b0);
        chk("pre_abort", act_m(), pk(1'b1, 1'b0, 1'b0, 3, 5));
        cyc(1'b0, 1'b0, 1'b1);
        chk("abort_idle", act_m(), pk(1'b0, 1'b0, 1'b0, 0, 0));
        dones = 0;
        for (int n = 0; n < 70; n++) begin
            cyc(1'b0, 1'b0, 1'b0);
            dones += int'(bus.byte_done) + int'(bus.busy);
        end
        chk("abort_quiet", dones, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("restart_first", act_m(), run_exp(0));
        for (int n = 1; n <= 63; n++) cyc(1'b0, 1'b0, 1'b0);
        chk("restart_done", act_m(), run_exp(63));

        // resync at bit 6, then start+stop together keeps RUN
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 48; n++) cyc(1'b0, 1'b0, 1'b0);
        chk("pre_resync", act_m(), pk(1'b1, 1'b0, 1'b0, 6, 1));
        cyc(1'b1, 1'b0, 1'b0);
        chk("resync", act_m(), run_exp(0));
        dones = 0;
        for (int m = 1; m <= 62; m++) begin
            cyc(1'b0, 1'b0, 1'b0);
            dones += int'(bus.byte_done);
        end
        chk("resync_no_early_done", dones, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("resync_done", act_m(), run_exp(63));
        cyc(1'b1, 1'b1, 1'b0);
        chk("start_stop_resync", act_m(), run_exp(0));
        for (int m = 1; m <= 63; m++) cyc(1'b0, 1'b0, 1'b0);
        chk("start_stop_done", act_m(), run_exp(63));
        cyc(1'b0, 1'b0, 1'b0);
        chk("start_stop_still_run", act_m(), run_exp(64));

        // asynchronous reset mid-RUN
        for (int m = 1; m <= 20; m++) cyc(1'b0, 1'b0, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_reset_main", act_m(), pk(1'b0, 1'b0, 1'b0, 0, 0));
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // minimal timing instance
        for (int i = 0; i < 11; i++) begin
            cyc_s(tbl_s[i].st, tbl_s[i].sp, tbl_s[i].ab);
            chk($sformatf("tbl_small[%0d]", i), act_s(),
                pk(tbl_s[i].busy, tbl_s[i].strb, tbl_s[i].done, tbl_s[i].idx, tbl_s[i].cnt));
        end
        #2;
        n_rst_s = 1'b0;
        #1;
        chk("async_reset_small", act_s(), pk(1'b0, 1'b0, 1'b0, 0, 0));
        @(posedge clk);
        #1;
        n_rst_s = 1'b1;
        cyc_s(1'b0, 1'b0, 1'b0);
        chk("small_after_reset", act_s(), pk(1'b0, 1'b0, 1'b0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
